// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage signal bundle: ID fields, forwarding sources, ALU-side outputs
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    // Pipeline control from the hazard unit
    logic              i_stall;
    logic              i_flush;

    // Decoded instruction from ID
    logic              i_valid;
    logic [DATA_W-1:0] i_rs_data;
    logic [DATA_W-1:0] i_rt_data;
    logic [DATA_W-1:0] i_imm;
    logic [4:0]        i_shamt;
    logic [REG_AW-1:0] i_rs_addr;
    logic [REG_AW-1:0] i_rt_addr;
    logic [REG_AW-1:0] i_dst_addr;
    logic [5:0]        i_alu_func;
    logic              i_alu_src;
    logic              i_reg_write;
    logic              i_mem_read;
    logic              i_mem_write;

    // Forwarding sources from later stages
    logic              i_exmem_wen;
    logic [REG_AW-1:0] i_exmem_addr;
    logic [DATA_W-1:0] i_exmem_data;
    logic              i_memwb_wen;
    logic [REG_AW-1:0] i_memwb_addr;
    logic [DATA_W-1:0] i_memwb_data;

    // EX-side results
    logic [DATA_W-1:0] o_op1;
    logic [DATA_W-1:0] o_op2;
    logic [5:0]        o_control;
    logic [DATA_W-1:0] o_store_data;
    logic [REG_AW-1:0] o_dst_addr;
    logic              o_valid;
    logic              o_reg_write;
    logic              o_mem_read;
    logic              o_mem_write;
    logic              o_load_use;

    // Pipeline side: ID, hazard unit and later stages drive, ALU side observes
    modport master (
        output i_stall, i_flush, i_valid, i_rs_data, i_rt_data, i_imm, i_shamt,
               i_rs_addr, i_rt_addr, i_dst_addr, i_alu_func, i_alu_src,
               i_reg_write, i_mem_read, i_mem_write,
               i_exmem_wen, i_exmem_addr, i_exmem_data,
               i_memwb_wen, i_memwb_addr, i_memwb_data,
        input  o_op1, o_op2, o_control, o_store_data, o_dst_addr, o_valid,
               o_reg_write, o_mem_read, o_mem_write, o_load_use
    );

    // The ID/EX stage itself
    modport slave (
        input  i_stall, i_flush, i_valid, i_rs_data, i_rt_data, i_imm, i_shamt,
               i_rs_addr, i_rt_addr, i_dst_addr, i_alu_func, i_alu_src,
               i_reg_write, i_mem_read, i_mem_write,
               i_exmem_wen, i_exmem_addr, i_exmem_data,
               i_memwb_wen, i_memwb_addr, i_memwb_data,
        output o_op1, o_op2, o_control, o_store_data, o_dst_addr, o_valid,
               o_reg_write, o_mem_read, o_mem_write, o_load_use
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detection
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    id_ex_stage_if.slave  bus
);
    localparam int SH_W = 5;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_ROTR  = 6'b111110;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_ROTRV = 6'b111111;

    // Stage registers
    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] rs_data_q,   rs_data_d;
    logic [DATA_W-1:0] rt_data_q,   rt_data_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [SH_W-1:0]   shamt_q,     shamt_d;
    logic [REG_AW-1:0] rs_addr_q,   rs_addr_d;
    logic [REG_AW-1:0] rt_addr_q,   rt_addr_d;
    logic [REG_AW-1:0] dst_q,       dst_d;
    logic [5:0]        func_q,      func_d;
    logic              alu_src_q,   alu_src_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;

    // Forwarded register values seen by EX
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Resolve rs/rt against the younger EX/MEM result first, then MEM/WB; r0 is hard zero
    always_comb begin
        fwd_rs = rs_data_q;
        if (rs_addr_q == '0) begin
            fwd_rs = '0;
        end else if (bus.i_exmem_wen && (bus.i_exmem_addr == rs_addr_q)) begin
            fwd_rs = bus.i_exmem_data;
        end else if (bus.i_memwb_wen && (bus.i_memwb_addr == rs_addr_q)) begin
            fwd_rs = bus.i_memwb_data;
        end

        fwd_rt = rt_data_q;
        if (rt_addr_q == '0) begin
            fwd_rt = '0;
        end else if (bus.i_exmem_wen && (bus.i_exmem_addr == rt_addr_q)) begin
            fwd_rt = bus.i_exmem_data;
        end else if (bus.i_memwb_wen && (bus.i_memwb_addr == rt_addr_q)) begin
            fwd_rt = bus.i_memwb_data;
        end
    end

    // Next-state: flush bubbles everything, stall holds fields but refreshes operand data
    always_comb begin
        valid_d     = valid_q;
        rs_data_d   = fwd_rs;
        rt_data_d   = fwd_rt;
        imm_d       = imm_q;
        shamt_d     = shamt_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        dst_d       = dst_q;
        func_d      = func_q;
        alu_src_d   = alu_src_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;

        if (bus.i_flush) begin
            valid_d     = 1'b0;
            rs_data_d   = '0;
            rt_data_d   = '0;
            imm_d       = '0;
            shamt_d     = '0;
            rs_addr_d   = '0;
            rt_addr_d   = '0;
            dst_d       = '0;
            func_d      = '0;
            alu_src_d   = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (!bus.i_stall) begin
            valid_d     = bus.i_valid;
            rs_data_d   = bus.i_rs_data;
            rt_data_d   = bus.i_rt_data;
            imm_d       = bus.i_imm;
            shamt_d     = bus.i_shamt;
            rs_addr_d   = bus.i_rs_addr;
            rt_addr_d   = bus.i_rt_addr;
            dst_d       = bus.i_dst_addr;
            func_d      = bus.i_alu_func;
            alu_src_d   = bus.i_alu_src;
            reg_write_d = bus.i_reg_write;
            mem_read_d  = bus.i_mem_read;
            mem_write_d = bus.i_mem_write;
        end
    end

    // Stage register with asynchronous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            shamt_q     <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            dst_q       <= '0;
            func_q      <= '0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
            shamt_q     <= shamt_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            dst_q       <= dst_d;
            func_q      <= func_d;
            alu_src_q   <= alu_src_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Operand 1: immediate shift amount, variable shift amount from rs, or rs itself
    always_comb begin
        bus.o_op1 = fwd_rs;
        case (func_q)
            FN_SLL, FN_SRL, FN_SRA, FN_ROTR:
                bus.o_op1 = {{(DATA_W-SH_W){1'b0}}, shamt_q};
            FN_SLLV, FN_SRLV, FN_SRAV, FN_ROTRV:
                bus.o_op1 = {{(DATA_W-SH_W){1'b0}}, fwd_rs[SH_W-1:0]};
            default:
                bus.o_op1 = fwd_rs;
        endcase
    end

    // Remaining EX outputs; memory/regfile controls only act for a real instruction
    always_comb begin
        bus.o_op2        = alu_src_q ? imm_q : fwd_rt;
        bus.o_store_data = fwd_rt;
        bus.o_control    = func_q;
        bus.o_dst_addr   = dst_q;
        bus.o_valid      = valid_q;
        bus.o_reg_write  = valid_q & reg_write_q;
        bus.o_mem_read   = valid_q & mem_read_q;
        bus.o_mem_write  = valid_q & mem_write_q;
    end

    // A load in EX whose target is read by the instruction in ID cannot be forwarded in time
    always_comb begin
        bus.o_load_use = valid_q & mem_read_q & bus.i_valid & (dst_q != '0) &
                         ((dst_q == bus.i_rs_addr) | (dst_q == bus.i_rt_addr));
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;
    logic clk;
    logic rst;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] store;
        logic [5:0]  ctrl;
        logic [4:0]  dst;
        logic        rw;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Monitor: every cycle EX shows a real instruction, pop and compare one expectation
    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        if (!rst && bus.o_valid) begin
            a = '{op1: bus.o_op1, op2: bus.o_op2, store: bus.o_store_data,
                  ctrl: bus.o_control, dst: bus.o_dst_addr, rw: bus.o_reg_write,
                  mr: bus.o_mem_read, mw: bus.o_mem_write};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: op1=%h op2=%h ctrl=%b with no expectation queued",
                         a.op1, a.op2, a.ctrl);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got op1=%h op2=%h st=%h ctrl=%b dst=%0d rw/mr/mw=%b%b%b, want op1=%h op2=%h st=%h ctrl=%b dst=%0d rw/mr/mw=%b%b%b",
                             nm, a.op1, a.op2, a.store, a.ctrl, a.dst, a.rw, a.mr, a.mw,
                             e.op1, e.op2, e.store, e.ctrl, e.dst, e.rw, e.mr, e.mw);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {bus.o_op1, bus.o_op2, bus.o_store_data, bus.o_control, bus.o_dst_addr,
                bus.o_valid, bus.o_reg_write, bus.o_mem_read, bus.o_mem_write, bus.o_load_use};
    endfunction

    task automatic drive_id(input logic [4:0] rs_a, input logic [31:0] rs_d,
                            input logic [4:0] rt_a, input logic [31:0] rt_d,
                            input logic [31:0] imm, input logic [4:0] sh,
                            input logic [4:0] dst, input logic [5:0] fn,
                            input logic src, input logic rw, input logic mr, input logic mw);
        bus.i_valid     = 1'b1;
        bus.i_rs_addr   = rs_a;
        bus.i_rs_data   = rs_d;
        bus.i_rt_addr   = rt_a;
        bus.i_rt_data   = rt_d;
        bus.i_imm       = imm;
        bus.i_shamt     = sh;
        bus.i_dst_addr  = dst;
        bus.i_alu_func  = fn;
        bus.i_alu_src   = src;
        bus.i_reg_write = rw;
        bus.i_mem_read  = mr;
        bus.i_mem_write = mw;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                           input logic mw, input logic [4:0] ma, input logic [31:0] md);
        bus.i_exmem_wen  = ew;
        bus.i_exmem_addr = ea;
        bus.i_exmem_data = ed;
        bus.i_memwb_wen  = mw;
        bus.i_memwb_addr = ma;
        bus.i_memwb_data = md;
    endtask

    // Capture the driven ID instruction and queue what EX must show for it
    task automatic issue(input string nm, input exp_t e);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        drive_id(5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.i_valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        #12;
        chk("reset_outputs", all_outs(), 128'd0);
        settle();
        rst = 1'b0;

        // ADD r3,r1,r2 with r1 forwarded from EX/MEM
        drive_id(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd0, 5'd3, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd1, 32'd100, 1'b0, 5'd0, 32'd0);
        issue("add_exmem_fwd", '{op1: 32'd100, op2: 32'd7, store: 32'd7, ctrl: 6'b100000,
                                 dst: 5'd3, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        settle();

        // Asynchronous reset mid-cycle clears outputs before any edge
        rst = 1'b1;
        #1;
        chk("async_reset_midrun", all_outs(), 128'd0);
        #1;
        rst = 1'b0;
        settle();

        // Both stages write r2: EX/MEM wins
        drive_id(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd0, 5'd3, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd2, 32'd9, 1'b1, 5'd2, 32'd4);
        issue("exmem_over_memwb", '{op1: 32'd5, op2: 32'd9, store: 32'd9, ctrl: 6'b100000,
                                    dst: 5'd3, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        settle();

        // r0 is never forwarded and always reads zero
        drive_id(5'd0, 32'h77, 5'd2, 32'd7, 32'd0, 5'd0, 5'd3, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd0, 32'd55, 1'b1, 5'd0, 32'd55);
        issue("r0_reads_zero", '{op1: 32'd0, op2: 32'd7, store: 32'd7, ctrl: 6'b100000,
                                 dst: 5'd3, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        settle();

        // MEM/WB-only forward on rt, EX/MEM targets a different register
        drive_id(5'd1, 32'd5, 5'd5, 32'd1, 32'd0, 5'd0, 5'd6, 6'b100010, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd6, 32'd99, 1'b1, 5'd5, 32'h0000ABCD);
        issue("memwb_fwd_rt", '{op1: 32'd5, op2: 32'h0000ABCD, store: 32'h0000ABCD, ctrl: 6'b100010,
                                dst: 5'd6, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        settle();

        // SLL: op1 is shamt
        drive_id(5'd0, 32'd0, 5'd2, 32'h1, 32'd0, 5'd3, 5'd3, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue("sll_shamt", '{op1: 32'd3, op2: 32'h1, store: 32'h1, ctrl: 6'b000000,
                             dst: 5'd3, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        settle();

        // SRAV: op1 is rs[4:0]
        drive_id(5'd1, 32'hFFFFFF25, 5'd2, 32'h80000000, 32'd0, 5'd0, 5'd3, 6'b000111, 1'b0, 1'b1, 1'b0, 1'b0);
        issue("srav_rs_low5", '{op1: 32'd5, op2: 32'h80000000, store: 32'h80000000, ctrl: 6'b000111,
                                dst: 5'd3, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        settle();

        // ROTR with the largest shift amount
        drive_id(5'd1, 32'hDEAD0000, 5'd2, 32'h12345678, 32'd0, 5'd31, 5'd4, 6'b111110, 1'b0, 1'b1, 1'b0, 1'b0);
        issue("rotr_shamt31", '{op1: 32'd31, op2: 32'h12345678, store: 32'h12345678, ctrl: 6'b111110,
                                dst: 5'd4, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        settle();

        // ROTRV with rs forwarded from EX/MEM, masked to 5 bits
        drive_id(5'd7, 32'd2, 5'd2, 32'd7, 32'd0, 5'd9, 5'd4, 6'b111111, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd7, 32'h0000003F, 1'b0, 5'd0, 32'd0);
        issue("rotrv_fwd_rs", '{op1: 32'h1F, op2: 32'd7, store: 32'd7, ctrl: 6'b111111,
                                dst: 5'd4, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        settle();

        // Store: op2 from imm, store data still carries forwarded rt
        drive_id(5'd1, 32'h1000, 5'd8, 32'h11, 32'hFFFFFFFC, 5'd0, 5'd0, 6'b100000, 1'b1, 1'b0, 1'b0, 1'b1);
        set_fwd(1'b1, 5'd8, 32'h22, 1'b0, 5'd0, 32'd0);
        issue("store_imm_fwd_rt", '{op1: 32'h1000, op2: 32'hFFFFFFFC, store: 32'h22, ctrl: 6'b100000,
                                    dst: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b1});
        settle();

        // LUI: immediate passes straight to op2
        drive_id(5'd0, 32'd0, 5'd9, 32'd0, 32'h0000BEEF, 5'd0, 5'd9, 6'b111100, 1'b1, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        issue("lui_imm", '{op1: 32'd0, op2: 32'h0000BEEF, store: 32'd0, ctrl: 6'b111100,
                           dst: 5'd9, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        settle();

        // LW r4 in EX, then probe load-use against ID reads
        drive_id(5'd2, 32'h100, 5'd4, 32'd0, 32'd8, 5'd0, 5'd4, 6'b100000, 1'b1, 1'b1, 1'b1, 1'b0);
        issue("lw_in_ex", '{op1: 32'h100, op2: 32'd8, store: 32'd0, ctrl: 6'b100000,
                            dst: 5'd4, rw: 1'b1, mr: 1'b1, mw: 1'b0});
        bus.i_valid = 1'b1; bus.i_rs_addr = 5'd4; bus.i_rt_addr = 5'd5;
        #1 chk("load_use_rs", 128'(bus.o_load_use), 128'd1);
        bus.i_rs_addr = 5'd6; bus.i_rt_addr = 5'd4;
        #1 chk("load_use_rt", 128'(bus.o_load_use), 128'd1);
        bus.i_rs_addr = 5'd6; bus.i_rt_addr = 5'd5;
        #1 chk("load_use_nomatch", 128'(bus.o_load_use), 128'd0);
        bus.i_rs_addr = 5'd4; bus.i_valid = 1'b0;
        #1 chk("load_use_id_invalid", 128'(bus.o_load_use), 128'd0);
        settle();
        bus.i_valid = 1'b1;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        chk("flush_bubble", {bus.o_valid, bus.o_reg_write, bus.o_mem_read, bus.o_control, bus.o_load_use}, 128'd0);
        settle();

        // Load with r0 target never requests a stall
        drive_id(5'd2, 32'h100, 5'd0, 32'd0, 32'd8, 5'd0, 5'd0, 6'b100000, 1'b1, 1'b1, 1'b1, 1'b0);
        issue("lw_r0", '{op1: 32'h100, op2: 32'd8, store: 32'd0, ctrl: 6'b100000,
                         dst: 5'd0, rw: 1'b1, mr: 1'b1, mw: 1'b0});
        bus.i_valid = 1'b1; bus.i_rs_addr = 5'd0; bus.i_rt_addr = 5'd0;
        #1 chk("load_use_r0", 128'(bus.o_load_use), 128'd0);
        bus.i_valid = 1'b0;
        settle();

        // Stall while MEM/WB retires r1: value must survive after MEM/WB drops
        drive_id(5'd1, 32'h10, 5'd2, 32'd3, 32'd0, 5'd0, 5'd7, 6'b100000, 1'b0, 1'b1, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'h1234);
        issue("stall_pre", '{op1: 32'h1234, op2: 32'd3, store: 32'd3, ctrl: 6'b100000,
                             dst: 5'd7, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        settle();
        drive_id(5'd11, 32'hAAAA, 5'd12, 32'hBBBB, 32'h5, 5'd2, 5'd9, 6'b100010, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.i_stall = 1'b1;
        @(posedge clk);
        #1;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        exp_q.push_back('{op1: 32'h1234, op2: 32'd3, store: 32'd3, ctrl: 6'b100000,
                          dst: 5'd7, rw: 1'b1, mr: 1'b0, mw: 1'b0});
        name_q.push_back("stall_hold");
        settle();
        bus.i_stall = 1'b0;
        bus.i_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Backstop against a stuck run
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1);
    end
endmodule
